// File: rtl/stream_mux_nx1_pkg.sv
// Shared definitions for the N:1 registered stream multiplexer:
// selection-mode encoding and a constant clog2 used to validate SEL_W.
package stream_mux_nx1_pkg;

  // Selection mode seen on the 1-bit mode input.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Ceiling log2 for elaboration-time parameter checks (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int acc;
    result = 0;
    acc    = 1;
    while (acc < value) begin
      acc    = acc * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Rotate-priority round-robin arbiter, purely combinational.
// Priority starts at ptr+1 and wraps NUM_CH-1 -> 0; the pointer register
// itself lives in the parent so the parent decides when it advances.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt_onehot,
  output logic [SEL_W-1:0]  gnt_id,
  output logic              gnt_any
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic                found;
  int                  start;
  int                  idx;

  // Rotate the request vector so ptr+1 sits at bit 0, pick the lowest set
  // bit, then map the winner back to an absolute channel id.
  always_comb begin
    start   = (int'(ptr) + 1) % NUM_CH;
    req_dbl = {req, req};
    req_rot = req_dbl[start +: NUM_CH];
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        idx   = (start + k) % NUM_CH;
      end
    end
  end

  // Gate the result with en so a blocked output stage never grants.
  always_comb begin
    gnt_onehot = '0;
    gnt_any    = en & found;
    gnt_id     = SEL_W'(idx);
    if (gnt_any) begin
      gnt_onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N:1 registered stream multiplexer.
// Picks one valid/ready producer channel per cycle (fixed select or
// round-robin) and forwards its beat through a single output register.
//
// Handshake: a beat moves on any port when valid & ready are both high at
// a rising clk edge; a producer keeps valid/data stable until it sees ready,
// and the output register keeps out_valid/out_data/out_ch stable until
// out_ready is seen with out_valid.
module stream_mux_nx1
  import stream_mux_nx1_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  // Refuse to elaborate with an inconsistent channel-id width.
  if (SEL_W != clog2(NUM_CH)) begin : g_bad_sel_w
    $error("stream_mux_nx1: SEL_W must equal clog2(NUM_CH)");
  end
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("stream_mux_nx1: NUM_CH must be at least 2");
  end

  // Output register and round-robin pointer.
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]  ptr_q,       ptr_d;

  // Grant path.
  logic              load_en;
  logic              grant_ok;
  logic              rr_en;
  logic [NUM_CH-1:0] rr_onehot;
  logic [SEL_W-1:0]  rr_id;
  logic              rr_any;
  logic [NUM_CH-1:0] fix_onehot;
  logic              fix_any;
  logic [NUM_CH-1:0] ready_c;
  logic [SEL_W-1:0]  gnt_id;
  logic              fire;
  logic [DATA_W-1:0] beat_data;

  // The register can take a new beat when empty or being drained this cycle;
  // nothing is granted while reset is asserted.
  always_comb begin
    load_en  = ~out_valid_q | out_ready;
    grant_ok = load_en & ~rst;
    rr_en    = grant_ok & (mode == MODE_RR);
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req        (in_valid),
    .ptr        (ptr_q),
    .en         (rr_en),
    .gnt_onehot (rr_onehot),
    .gnt_id     (rr_id),
    .gnt_any    (rr_any)
  );

  // Decode sel to a one-hot; out-of-range values decode to nothing.
  always_comb begin
    fix_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        fix_onehot[i] = 1'b1;
      end
    end
    fix_any = |fix_onehot;
  end

  // Pick the active grant source and form the per-channel ready vector.
  always_comb begin
    ready_c = '0;
    gnt_id  = '0;
    if (mode == MODE_RR) begin
      ready_c = rr_onehot & in_valid;
      gnt_id  = rr_any ? rr_id : '0;
    end else begin
      ready_c = grant_ok ? (fix_onehot & in_valid) : '0;
      gnt_id  = fix_any ? sel : '0;
    end
    fire = |ready_c;
  end

  // Payload of the granted channel; only consumed when fire is high.
  always_comb begin
    beat_data = in_data[int'(gnt_id)*DATA_W +: DATA_W];
  end

  // Next state: load on transfer, drain to empty otherwise, hold while
  // blocked. The pointer only moves on a round-robin transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = fire;
    end
    if (fire) begin
      out_data_d = beat_data;
      out_ch_d   = gnt_id;
      if (mode == MODE_RR) begin
        ptr_d = gnt_id;
      end
    end
  end

  // State registers; reset discards any held beat and gives channel 0
  // first round-robin priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  // Drive ports from the registered state and the grant.
  always_comb begin
    in_ready  = ready_c;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_ch    = out_ch_q;
  end

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed bench for stream_mux_nx1: stimulus pushes hand-computed beats
// into exp_q, a negedge monitor pops them as the output is accepted.
module tb_stream_mux_nx1;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (4 channels) ----------------
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;
  logic [7:0]               base;

  stream_mux_nx1 #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  // Channel i carries base + i.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) in_data[i*DATA_W +: DATA_W] = base + 8'(i);
  end

  // ---------------- DUT (3 channels, sel=3 is out of range) ----------------
  logic [2:0] in_ready3;
  logic       out_valid3;
  logic [7:0] out_data3;
  logic [1:0] out_ch3;

  stream_mux_nx1 #(.NUM_CH(3), .DATA_W(8), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (1'b0),
    .sel       (2'd3),
    .in_valid  (3'b111),
    .in_data   (24'h332211),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_ready (1'b1)
  );

  // ---------------- scoreboard ----------------
  logic [SEL_W+DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got ch=%0d data=%0h, required no beat", out_ch, out_data);
      end else begin
        logic [SEL_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({out_ch, out_data} !== e) begin
          errors++;
          $display("FAIL beat: got ch=%0d data=%0h, required ch=%0d data=%0h",
                   out_ch, out_data, e[SEL_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: check in_ready at negedge, optionally expect a transfer from
  // channel exp_ch, then advance to just after the next rising edge.
  task automatic drive_cycle(input string name, input logic [3:0] exp_rdy,
                             input logic push, input logic [1:0] exp_ch);
    @(negedge clk);
    chk(name, in_ready, exp_rdy);
    if (push) exp_q.push_back({exp_ch, base + 8'(exp_ch)});
    @(posedge clk); #1;
  endtask

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [1:0] rr_all  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0] rr_1010 [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

  initial begin
    mode = 1'b1; sel = '0; in_valid = 4'b1111; out_ready = 1'b1; base = 8'h20;

    // 1: reset held 3 clocks with all inputs valid.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // 4a: round-robin, all valid: 0,1,2,3,0,1 (first grant ch0).
    for (int i = 0; i < 6; i++) drive_cycle("rr_all_ready", 4'b0001 << rr_all[i], 1'b1, rr_all[i]);

    // 2: fixed select ch2.
    mode = 1'b0; sel = 2'd2; base = 8'h10;
    for (int i = 0; i < 4; i++) drive_cycle("fix_sel2_ready", 4'b0100, 1'b1, 2'd2);
    // 3: 3-channel build with sel=3 never grants.
    chk("inv_sel_ready", in_ready3, 0);
    chk("inv_sel_valid", out_valid3, 0);
    // Fixed select of a channel that is not valid: no grant.
    sel = 2'd1; in_valid = 4'b1101;
    drive_cycle("fix_not_valid_ready", 4'b0000, 1'b0, 2'd0);
    in_valid = 4'b1111;
    drive_cycle("fix_sel1_ready", 4'b0010, 1'b1, 2'd1);

    // Fixed mode left the pointer at ch1: round-robin resumes at ch2.
    mode = 1'b1; base = 8'h30;
    drive_cycle("rr_resume_ready", 4'b0100, 1'b1, 2'd2);
    drive_cycle("rr_resume_ready", 4'b1000, 1'b1, 2'd3);
    in_valid = 4'b0000;
    drive_cycle("drain_ready", 4'b0000, 1'b0, 2'd0);

    // Reset pulse while idle, then the 1010 wrap check from power-up state.
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 4'b1010; base = 8'h40;
    for (int i = 0; i < 4; i++) drive_cycle("rr_1010_ready", 4'b0001 << rr_1010[i], 1'b1, rr_1010[i]);
    in_valid = 4'b0000;
    drive_cycle("drain_ready", 4'b0000, 1'b0, 2'd0);

    // 5: backpressure. Pointer is at ch3, so ch0 loads first.
    in_valid = 4'b1111; out_ready = 1'b0; base = 8'h60;
    drive_cycle("bp_load_ready", 4'b0001, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin mode = 1'b0; sel = 2'd1; end
      if (i == 2) mode = 1'b1;
      @(negedge clk);
      chk("bp_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_ch", out_ch, 0);
      chk("bp_out_data", out_data, 8'h60);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive_cycle("bp_release_ready", 4'b0010, 1'b1, 2'd1);
    in_valid = 4'b0000;
    drive_cycle("drain_ready", 4'b0000, 1'b0, 2'd0);
    chk("drain_out_valid", out_valid, 0);

    // 6: reset while a beat is held under backpressure.
    in_valid = 4'b0100; out_ready = 1'b0; base = 8'h80;
    drive_cycle("rst6_load_ready", 4'b0100, 1'b0, 2'd0);
    in_valid = 4'b0000;
    chk("rst6_held_valid", out_valid, 1);
    chk("rst6_held_ch", out_ch, 2);
    chk("rst6_held_data", out_data, 8'h82);
    chk("sb_empty_before_rst", exp_q.size(), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst6_out_valid", out_valid, 0);
    chk("rst6_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle("post_rst_idle_ready", 4'b0000, 1'b0, 2'd0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
